ifu: RTL

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ifu
//  Description : Single-outstanding instruction fetch unit with redirect and
//                decode handshake. Optional misaligned-redirect trap is
//                enabled by defining IFU_MISALIGN_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    logic        w_redirect_live;
    logic        w_redirect_bad;
    logic [31:0] w_redirect_target;

`ifdef IFU_MISALIGN_CHECK_EN
    assign w_redirect_bad    = |redirect_pc[1:0];
    assign w_redirect_target = redirect_pc;
`else
    // Low bits are simply dropped; a misaligned target can never trap.
    logic w_unused_redirect_lsbs;
    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];
    assign w_redirect_bad         = 1'b0;
    assign w_redirect_target      = {redirect_pc[31:2], 2'b00};
`endif

    // A trapped unit ignores redirects; only reset recovers it.
    assign w_redirect_live = redirect && (state_q != S_TRAP);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        if (w_redirect_live) begin
            if (w_redirect_bad) begin
                state_d = S_TRAP;
            end else begin
                state_d = S_FETCH;
                pc_d    = w_redirect_target;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_q | (w_redirect_live & w_redirect_bad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // Handshake outputs are masked while reset is asserted.
    assign imem_req   = !rst && (state_q == S_FETCH);
    assign inst_valid = !rst && (state_q == S_HOLD);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule
`default_nettype wire
